cv32e40p_mult_sched_ft: RTL and testbench
=========================================

# cv32e40p_mult_sched_ft

Scheduler for the triplicated fault-tolerant multiplier.
- Accepts one multiply request at a time.
- Snapshots the permanent-fault map to pick the healthy units for the operation class.
- Drives those units, then combines their results: TMR majority vote, DMR compare with bounded retry, or simplex.
- Returns one response and pulses per-unit `error_detected` into the multiplier error counters.
- Sits between the EX-stage multiply issue and the three mult instances.

## Interface
Parameters:
- `MAX_RETRY`, 2: DMR re-executions allowed after a mismatch before the response is flagged unrecoverable.
- `TIMEOUT`, 16: maximum cycles spent in WAIT before units that have not answered are declared erroneous.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: scheduler can accept a request.
- `operator_i` in 3: mult operator, `cv32e40p_pkg` `MUL_*` encoding.
- `op_a_i`, `op_b_i`, `op_c_i` in 32 each: operands.
- `permanent_faulty_mult_i` in [2:0][3:0]: faulty map, indexed [unit][class].
- `mult_enable_o` out 3: per-unit enable.
- `mult_operator_o` out [2:0][2:0]: latched operator, fanned to each unit.
- `mult_op_a_o`, `mult_op_b_o`, `mult_op_c_o` out 32 each: latched operands, shared by all units.
- `unit_valid_i` in 3: per-unit result-valid pulse.
- `unit_result_i` in [2:0][31:0]: per-unit result.
- `error_detected_o` out 3: one-cycle error pulse per unit.
- `resp_valid_o` out 1: response valid.
- `resp_ready_i` in 1: consumer accepts response.
- `resp_result_o` out 32: final result.
- `resp_err_o` out 1: result is not trustworthy.

## Operation
- Class derivation:
  - class 0: `MUL_MAC32`, `MUL_MSU32`
  - class 1: `MUL_I`, `MUL_IR`, `MUL_H`
  - class 2: `MUL_DOT8`
  - class 3: `MUL_DOT16`
  - Any other operator uses class 0.
- Healthy mask: `hm[k] = ~permanent_faulty_mult_i[k][class]`, latched at accept. Later changes to the map do not affect the request in flight.
- Mode from the popcount of `hm`: 3 → TMR, 2 → DMR, 1 → SIMPLEX, 0 → NONE.
- States:
  - **IDLE:** `req_ready_o=1`. On `req_valid_i`, latch operator, operands and `hm`; clear `retry_cnt`. Mode NONE goes to RESP with result 0 and `resp_err_o=1`. Every other mode goes to ISSUE.
  - **ISSUE** (1 cycle): `mult_enable_o=hm`; clear done-mask and the WAIT timer. Go to WAIT.
  - **WAIT:**
    - `mult_enable_o = hm & ~done`. `unit_valid_i` is sampled in ISSUE and WAIT, and its result is latched into a per-unit register.
    - When `done==hm`, go to VOTE.
    - If the timer reaches `TIMEOUT`, units not in `done` are marked missing and the state goes to VOTE.
  - **VOTE** (1 cycle):
    - TMR: result is the bitwise majority of the three registers. A missing unit contributes 0. Unit k is erroneous if missing or its register differs from the majority. `resp_err_o=1` only if two or more units are erroneous.
    - DMR: if both units are present and equal, result is the common value. Otherwise both units are erroneous. If `retry_cnt<MAX_RETRY`, increment it and go to ISSUE with no response. If not, result is the lower-index present unit's register (0 if both are missing), with `resp_err_o=1`.
    - SIMPLEX: result is the register value. `resp_err_o=1` only if the unit is missing.
    - `error_detected_o` pulses the erroneous units in this cycle, including on retries.
  - **RESP:** `resp_valid_o=1`; result and error flag are held stable. When `resp_ready_i` is seen, go to IDLE.
- `unit_valid_i` seen outside ISSUE/WAIT is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; latched operator, operands, registers and counters 0. `req_ready_o` rises in the first cycle after reset deasserts.
- Reset mid-operation discards the request immediately: no response and no error pulse.
- Minimum latency with single-cycle units:
  - accept at edge T
  - ISSUE during cycle T+1
  - VOTE during T+2
  - `resp_valid_o` from T+3
- Each DMR retry adds at least 2 cycles.
- Back-to-back requests: the next accept happens no earlier than the cycle after the response handshake. No overlap between requests.
- The WAIT timer is 5 bits and saturates; `TIMEOUT` must be at least 1.
- `mult_operator_o` and the operand outputs are stable from ISSUE through VOTE.

## Structure
- Shared package `cv32e40p_pkg` holds:
  - the `mult_sched_state_e` enum (IDLE, ISSUE, WAIT, VOTE, RESP)
  - the `mult_class_e` enum
  - a constant `MULT_SCHED_TIMEOUT`, default 16
- Natural sub-module: `cv32e40p_mult_voter_ft`. It is combinational: three results plus present/healthy masks in; voted result, erroneous mask and err flag out.

## Test plan
- **TMR clean:** all healthy, `MUL_MAC32`, units return 0x12345678 on the ISSUE cycle → response at T+3 = 0x12345678, `resp_err_o=0`, no error pulses.
- **TMR single fault:** unit 1 returns 0x0 and units 0/2 return 0xDEADBEEF → result 0xDEADBEEF, `error_detected_o=3'b010` for one cycle, `resp_err_o=0`.
- **DMR retry:**
  - Setup: map `[0][2]=1`, `MUL_DOT8`.
  - Stimulus: first attempt units 1/2 return 5/7; second attempt both return 5.
  - Required: two ISSUE phases, `error_detected_o=3'b110` once, result 5, `resp_err_o=0`.
- **DMR exhaust:** persistent mismatch 5/7 with `MAX_RETRY=2` → three issues, three 3'b110 pulses, result 5, `resp_err_o=1`.
- **Timeout and NONE:**
  - Timeout: SIMPLEX (units 1/2 faulty in class 0) and unit 0 never answers → after 16 WAIT cycles, result 0, `resp_err_o=1`, pulse 3'b001.
  - NONE: all faulty → response at T+1 with result 0, `resp_err_o=1`.
- **Backpressure/reset:**
  - Backpressure: hold `resp_ready_i=0` for 5 cycles → response stable, `req_ready_o=0`.
  - Reset: assert `rst` during WAIT → all outputs 0 immediately, IDLE after release, no stale response.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the fault-tolerant multiplier scheduler.
package cv32e40p_pkg;

    localparam int unsigned MULT_OP_W          = 3;
    localparam int unsigned MULT_NUM_UNITS     = 3;
    localparam int unsigned MULT_NUM_CLASSES   = 4;
    localparam int unsigned MULT_SCHED_TIMEOUT = 16;
    localparam int unsigned MULT_TIMER_W       = 5;

    localparam logic [MULT_OP_W-1:0] MUL_MAC32 = 3'b000;
    localparam logic [MULT_OP_W-1:0] MUL_MSU32 = 3'b001;
    localparam logic [MULT_OP_W-1:0] MUL_I     = 3'b010;
    localparam logic [MULT_OP_W-1:0] MUL_IR    = 3'b011;
    localparam logic [MULT_OP_W-1:0] MUL_DOT8  = 3'b100;
    localparam logic [MULT_OP_W-1:0] MUL_DOT16 = 3'b101;
    localparam logic [MULT_OP_W-1:0] MUL_H     = 3'b110;

    typedef enum logic [2:0] {
        SCHED_IDLE  = 3'd0,
        SCHED_ISSUE = 3'd1,
        SCHED_WAIT  = 3'd2,
        SCHED_VOTE  = 3'd3,
        SCHED_RESP  = 3'd4
    } mult_sched_state_e;

    typedef enum logic [1:0] {
        CLS_MAC   = 2'd0,
        CLS_MUL   = 2'd1,
        CLS_DOT8  = 2'd2,
        CLS_DOT16 = 2'd3
    } mult_class_e;

    // Encoding equals the number of healthy units.
    typedef enum logic [1:0] {
        MODE_NONE    = 2'd0,
        MODE_SIMPLEX = 2'd1,
        MODE_DMR     = 2'd2,
        MODE_TMR     = 2'd3
    } mult_mode_e;

    function automatic mult_class_e mult_class(input logic [MULT_OP_W-1:0] op);
        case (op)
            MUL_MAC32, MUL_MSU32:  return CLS_MAC;
            MUL_I, MUL_IR, MUL_H:  return CLS_MUL;
            MUL_DOT8:              return CLS_DOT8;
            MUL_DOT16:             return CLS_DOT16;
            default:               return CLS_MAC;
        endcase
    endfunction

    function automatic mult_mode_e mult_mode(input logic [MULT_NUM_UNITS-1:0] hm);
        return mult_mode_e'(2'(hm[0]) + 2'(hm[1]) + 2'(hm[2]));
    endfunction

endpackage

// File: rtl/cv32e40p_mult_voter_ft.sv
// Combinational result combiner: TMR majority, DMR compare or simplex pass-through.
module cv32e40p_mult_voter_ft
    import cv32e40p_pkg::*;
(
    input  logic [2:0][31:0] results,
    input  logic [2:0]       present,
    input  logic [2:0]       healthy,
    output logic [31:0]      voted,
    output logic [2:0]       erroneous,
    output logic             err
);

    logic [2:0][31:0] masked;
    logic [31:0]      maj;
    logic [1:0]       lo;
    logic [1:0]       hi;

    always_comb begin
        voted     = '0;
        erroneous = '0;
        err       = 1'b0;
        maj       = '0;
        lo        = healthy[0] ? 2'd0 : 2'd1;
        hi        = healthy[2] ? 2'd2 : 2'd1;
        for (int k = 0; k < 3; k++) begin
            masked[k] = present[k] ? results[k] : 32'h0;
        end

        case (mult_mode(healthy))
            MODE_TMR: begin
                maj   = (masked[0] & masked[1]) | (masked[0] & masked[2]) | (masked[1] & masked[2]);
                voted = maj;
                for (int k = 0; k < 3; k++) begin
                    erroneous[k] = ~present[k] | (masked[k] != maj);
                end
                err = (erroneous[0] & erroneous[1]) | (erroneous[0] & erroneous[2]) |
                      (erroneous[1] & erroneous[2]);
            end
            MODE_DMR: begin
                if (present[lo] && present[hi] && (results[lo] == results[hi])) begin
                    voted = results[lo];
                end else begin
                    erroneous = healthy;
                    err       = 1'b1;
                    voted     = present[lo] ? results[lo] : masked[hi];
                end
            end
            MODE_SIMPLEX: begin
                // Only the single healthy unit can be present.
                voted     = masked[0] | masked[1] | masked[2];
                erroneous = healthy & ~present;
                err       = |erroneous;
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cv32e40p_mult_sched_ft.sv
// Scheduler for the triplicated multiplier: issue to healthy units, collect, vote, respond.
module cv32e40p_mult_sched_ft
    import cv32e40p_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned TIMEOUT   = MULT_SCHED_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       operator_i,
    input  logic [31:0]      op_a_i,
    input  logic [31:0]      op_b_i,
    input  logic [31:0]      op_c_i,
    input  logic [2:0][3:0]  permanent_faulty_mult_i,
    output logic [2:0]       mult_enable_o,
    output logic [2:0][2:0]  mult_operator_o,
    output logic [31:0]      mult_op_a_o,
    output logic [31:0]      mult_op_b_o,
    output logic [31:0]      mult_op_c_o,
    input  logic [2:0]       unit_valid_i,
    input  logic [2:0][31:0] unit_result_i,
    output logic [2:0]       error_detected_o,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [31:0]      resp_result_o,
    output logic             resp_err_o
);

    localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    mult_sched_state_e state_q, state_d;

    logic [2:0]         op_q, op_d;
    logic [31:0]        a_q, a_d, b_q, b_d, c_q, c_d;
    logic [2:0]         hm_q, hm_d;
    logic [2:0]         done_q, done_d, done_cur;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [MULT_TIMER_W-1:0] timer_q, timer_d;
    logic [2:0][31:0]   res_q, res_d;
    logic [31:0]        vote_result_q;
    logic               vote_err_q;
    logic [31:0]        vote_result_c;
    logic [2:0]         vote_erroneous_c;
    logic               vote_err_c;
    mult_class_e        cls_c;

    // Voting runs on the values being captured, so its outputs are registered on VOTE entry.
    cv32e40p_mult_voter_ft u_voter (
        .results   (res_d),
        .present   (done_d),
        .healthy   (hm_q),
        .voted     (vote_result_c),
        .erroneous (vote_erroneous_c),
        .err       (vote_err_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SCHED_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        hm_d     = hm_q;
        done_d   = done_q;
        done_cur = done_q;
        retry_d  = retry_q;
        timer_d  = timer_q;
        res_d    = res_q;
        cls_c    = mult_class(operator_i);

        case (state_q)
            SCHED_IDLE: begin
                if (req_valid_i) begin
                    op_d    = operator_i;
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    c_d     = op_c_i;
                    retry_d = '0;
                    for (int k = 0; k < 3; k++) begin
                        hm_d[k] = ~permanent_faulty_mult_i[k][cls_c];
                    end
                    state_d = (hm_d == 3'b000) ? SCHED_RESP : SCHED_ISSUE;
                end
            end
            SCHED_ISSUE, SCHED_WAIT: begin
                if (state_q == SCHED_ISSUE) begin
                    done_cur = '0;
                    timer_d  = '0;
                end else begin
                    timer_d = (timer_q == '1) ? timer_q : timer_q + MULT_TIMER_W'(1);
                end
                for (int k = 0; k < 3; k++) begin
                    if (unit_valid_i[k] && hm_q[k] && !done_cur[k]) res_d[k] = unit_result_i[k];
                end
                done_d = done_cur | (unit_valid_i & hm_q);
                if (done_d == hm_q)
                    state_d = SCHED_VOTE;
                else if ((state_q == SCHED_WAIT) && (timer_d >= MULT_TIMER_W'(TIMEOUT)))
                    state_d = SCHED_VOTE;
                else
                    state_d = SCHED_WAIT;
            end
            SCHED_VOTE: begin
                if ((mult_mode(hm_q) == MODE_DMR) && vote_err_q &&
                    (retry_q < RETRY_W'(MAX_RETRY))) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = SCHED_ISSUE;
                end else begin
                    state_d = SCHED_RESP;
                end
            end
            SCHED_RESP: begin
                if (resp_ready_i) state_d = SCHED_IDLE;
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    // Request context and per-unit result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            hm_q    <= '0;
            done_q  <= '0;
            retry_q <= '0;
            timer_q <= '0;
            res_q   <= '0;
        end else begin
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            hm_q    <= hm_d;
            done_q  <= done_d;
            retry_q <= retry_d;
            timer_q <= timer_d;
            res_q   <= res_d;
        end
    end

    // Registered outputs, computed from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_o      <= 1'b0;
            mult_enable_o    <= '0;
            error_detected_o <= '0;
            vote_result_q    <= '0;
            vote_err_q       <= 1'b0;
            resp_valid_o     <= 1'b0;
            resp_result_o    <= '0;
            resp_err_o       <= 1'b0;
        end else begin
            req_ready_o      <= (state_d == SCHED_IDLE);
            mult_enable_o    <= (state_d == SCHED_ISSUE) ? hm_d :
                                (state_d == SCHED_WAIT)  ? (hm_d & ~done_d) : 3'b000;
            error_detected_o <= (state_d == SCHED_VOTE) ? vote_erroneous_c : 3'b000;
            if (state_d == SCHED_VOTE) begin
                vote_result_q <= vote_result_c;
                vote_err_q    <= vote_err_c;
            end
            if ((state_q != SCHED_RESP) && (state_d == SCHED_RESP)) begin
                resp_valid_o  <= 1'b1;
                resp_result_o <= (state_q == SCHED_VOTE) ? vote_result_q : 32'h0;
                resp_err_o    <= (state_q == SCHED_VOTE) ? vote_err_q : 1'b1;
            end else if ((state_q == SCHED_RESP) && (state_d == SCHED_IDLE)) begin
                resp_valid_o <= 1'b0;
            end
        end
    end

    assign mult_operator_o = {3{op_q}};
    assign mult_op_a_o     = a_q;
    assign mult_op_b_o     = b_q;
    assign mult_op_c_o     = c_q;

endmodule

// File: tb/tb_cv32e40p_mult_sched_ft.sv
// Directed bench for the multiplier scheduler with a scripted per-attempt unit model.
module tb_cv32e40p_mult_sched_ft;
    import cv32e40p_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [2:0]       operator_i;
    logic [31:0]      op_a_i, op_b_i, op_c_i;
    logic [2:0][3:0]  permanent_faulty_mult_i;
    logic [2:0]       mult_enable_o;
    logic [2:0][2:0]  mult_operator_o;
    logic [31:0]      mult_op_a_o, mult_op_b_o, mult_op_c_o;
    logic [2:0]       unit_valid_i;
    logic [2:0][31:0] unit_result_i;
    logic [2:0]       error_detected_o;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic [31:0]      resp_result_o;
    logic             resp_err_o;

    cv32e40p_mult_sched_ft #(.MAX_RETRY(2), .TIMEOUT(16)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .req_valid_i             (req_valid_i),
        .req_ready_o             (req_ready_o),
        .operator_i              (operator_i),
        .op_a_i                  (op_a_i),
        .op_b_i                  (op_b_i),
        .op_c_i                  (op_c_i),
        .permanent_faulty_mult_i (permanent_faulty_mult_i),
        .mult_enable_o           (mult_enable_o),
        .mult_operator_o         (mult_operator_o),
        .mult_op_a_o             (mult_op_a_o),
        .mult_op_b_o             (mult_op_b_o),
        .mult_op_c_o             (mult_op_c_o),
        .unit_valid_i            (unit_valid_i),
        .unit_result_i           (unit_result_i),
        .error_detected_o        (error_detected_o),
        .resp_valid_o            (resp_valid_o),
        .resp_ready_i            (resp_ready_i),
        .resp_result_o           (resp_result_o),
        .resp_err_o              (resp_err_o)
    );

    always #5 clk = ~clk;

    // Enabled units answer in the same cycle when allowed to.
    logic [2:0]  respond_mask;
    assign unit_valid_i = mult_enable_o & respond_mask;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] att_val [3][3];
    int          lat, issues, pulses;
    logic [2:0]  last_pulse, first_en;
    logic [31:0] first_a, resp_res;
    logic        resp_e, timed_out;
    logic [2:0][3:0] map;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_att(input int idx, input logic [31:0] u0, input logic [31:0] u1,
                           input logic [31:0] u2);
        att_val[idx][0] = u0;
        att_val[idx][1] = u1;
        att_val[idx][2] = u2;
    endtask

    task automatic run_req(input logic [2:0] op, input logic [2:0][3:0] fmap,
                           input logic [31:0] a, input int hold);
        logic [2:0] prev_en;
        int         idx;
        prev_en    = 3'b000;
        issues     = 0;
        pulses     = 0;
        last_pulse = 3'b000;
        first_en   = 3'b000;
        first_a    = 32'h0;
        lat        = 0;
        timed_out  = 1'b1;
        check("ready_before_req", 32'(req_ready_o), 32'd1);
        req_valid_i             = 1'b1;
        operator_i              = op;
        op_a_i                  = a;
        op_b_i                  = ~a;
        op_c_i                  = a ^ 32'h5a5a_5a5a;
        permanent_faulty_mult_i = fmap;
        step();
        req_valid_i             = 1'b0;
        permanent_faulty_mult_i = '1;
        for (int c = 1; c <= 60; c++) begin
            if ((mult_enable_o != 3'b000) && (prev_en == 3'b000)) begin
                if (issues == 0) begin
                    first_en = mult_enable_o;
                    first_a  = mult_op_a_o;
                end
                idx = (issues > 2) ? 2 : issues;
                for (int k = 0; k < 3; k++) unit_result_i[k] = att_val[idx][k];
                issues++;
            end
            prev_en = mult_enable_o;
            if (error_detected_o != 3'b000) begin
                pulses++;
                last_pulse = error_detected_o;
            end
            if (resp_valid_o) begin
                lat       = c;
                timed_out = 1'b0;
                break;
            end
            step();
        end
        check("resp_wait_bound", 32'(timed_out), 32'd0);
        resp_res = resp_result_o;
        resp_e   = resp_err_o;
        for (int h = 0; h < hold; h++) begin
            step();
            check("bp_valid", 32'(resp_valid_o), 32'd1);
            check("bp_result", resp_result_o, resp_res);
            check("bp_err", 32'(resp_err_o), 32'(resp_e));
            check("bp_req_ready", 32'(req_ready_o), 32'd0);
        end
        resp_ready_i = 1'b1;
        step();
        resp_ready_i = 1'b0;
        check("post_resp_valid", 32'(resp_valid_o), 32'd0);
        check("post_req_ready", 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0;
        operator_i = 3'b000;
        op_a_i = '0;
        op_b_i = '0;
        op_c_i = '0;
        permanent_faulty_mult_i = '0;
        resp_ready_i = 1'b0;
        respond_mask = 3'b000;
        unit_result_i = '0;
        for (int i = 0; i < 3; i++) set_att(i, 32'h0, 32'h0, 32'h0);
        step();
        step();
        check("rst_req_ready", 32'(req_ready_o), 32'd0);
        check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst_enable", 32'(mult_enable_o), 32'd0);
        check("rst_op_a", mult_op_a_o, 32'h0);
        rst = 1'b0;
        check("rel_req_ready_low", 32'(req_ready_o), 32'd0);
        step();
        check("rel_req_ready_high", 32'(req_ready_o), 32'd1);

        // TMR clean
        respond_mask = 3'b111;
        for (int i = 0; i < 3; i++) set_att(i, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
        run_req(MUL_MAC32, '0, 32'ha5a5_0001, 0);
        check("tmr_lat", 32'(lat), 32'd3);
        check("tmr_result", resp_res, 32'h1234_5678);
        check("tmr_err", 32'(resp_e), 32'd0);
        check("tmr_pulses", 32'(pulses), 32'd0);
        check("tmr_issues", 32'(issues), 32'd1);
        check("tmr_enable", 32'(first_en), 32'h7);
        check("tmr_op_a", first_a, 32'ha5a5_0001);

        // TMR single fault on unit 1, with 5 cycles of backpressure
        for (int i = 0; i < 3; i++) set_att(i, 32'hdead_beef, 32'h0, 32'hdead_beef);
        run_req(MUL_I, '0, 32'h0000_0002, 5);
        check("tmr1_result", resp_res, 32'hdead_beef);
        check("tmr1_err", 32'(resp_e), 32'd0);
        check("tmr1_pulses", 32'(pulses), 32'd1);
        check("tmr1_pulse_val", 32'(last_pulse), 32'h2);

        // DMR with one retry
        map = '0;
        map[0][2] = 1'b1;
        set_att(0, 32'h0, 32'd5, 32'd7);
        set_att(1, 32'h0, 32'd5, 32'd5);
        set_att(2, 32'h0, 32'd5, 32'd5);
        run_req(MUL_DOT8, map, 32'h0000_0003, 0);
        check("dmr_issues", 32'(issues), 32'd2);
        check("dmr_enable", 32'(first_en), 32'h6);
        check("dmr_pulses", 32'(pulses), 32'd1);
        check("dmr_pulse_val", 32'(last_pulse), 32'h6);
        check("dmr_result", resp_res, 32'd5);
        check("dmr_err", 32'(resp_e), 32'd0);
        check("dmr_lat", 32'(lat), 32'd5);

        // DMR retries exhausted
        for (int i = 0; i < 3; i++) set_att(i, 32'h0, 32'd5, 32'd7);
        run_req(MUL_DOT8, map, 32'h0000_0004, 0);
        check("dmrx_issues", 32'(issues), 32'd3);
        check("dmrx_pulses", 32'(pulses), 32'd3);
        check("dmrx_pulse_val", 32'(last_pulse), 32'h6);
        check("dmrx_result", resp_res, 32'd5);
        check("dmrx_err", 32'(resp_e), 32'd1);
        check("dmrx_lat", 32'(lat), 32'd7);

        // SIMPLEX timeout: unit 0 never answers
        respond_mask = 3'b000;
        map = '0;
        map[1][0] = 1'b1;
        map[2][0] = 1'b1;
        run_req(MUL_MSU32, map, 32'h0000_0005, 0);
        check("to_enable", 32'(first_en), 32'h1);
        check("to_lat", 32'(lat), 32'd19);
        check("to_result", resp_res, 32'h0);
        check("to_err", 32'(resp_e), 32'd1);
        check("to_pulses", 32'(pulses), 32'd1);
        check("to_pulse_val", 32'(last_pulse), 32'h1);

        // NONE: no healthy unit
        run_req(MUL_H, '1, 32'h0000_0006, 0);
        check("none_lat", 32'(lat), 32'd1);
        check("none_result", resp_res, 32'h0);
        check("none_err", 32'(resp_e), 32'd1);
        check("none_issues", 32'(issues), 32'd0);

        // Reset during WAIT discards the request
        req_valid_i = 1'b1;
        operator_i = MUL_MAC32;
        op_a_i = 32'h0000_0077;
        permanent_faulty_mult_i = map;
        step();
        req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("mid_enable", 32'(mult_enable_o), 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_enable", 32'(mult_enable_o), 32'h0);
        check("mid_rst_ready", 32'(req_ready_o), 32'd0);
        check("mid_rst_op_a", mult_op_a_o, 32'h0);
        check("mid_rst_errdet", 32'(error_detected_o), 32'h0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            check("post_rst_no_resp", 32'(resp_valid_o), 32'd0);
            check("post_rst_no_pulse", 32'(error_detected_o), 32'h0);
        end
        check("post_rst_ready", 32'(req_ready_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
